// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch sequencer: reads the low byte at PC and the high byte at PC+1,
// loads each into the IR through its byte-load FunSel and steps the PC Register.
module ir_fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] PC,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  input  logic        MemValid,
  input  logic [7:0]  MemData,
  output logic        IRE,
  output logic [2:0]  IRFunSel,
  output logic [15:0] IRI,
  output logic        PCE,
  output logic [2:0]  PCFunSel,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  localparam logic [2:0] FS_NONE    = 3'b000;
  localparam logic [2:0] FS_LOAD_LO = 3'b101;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_LD_LO,
    S_RD_HI,
    S_LD_HI,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_read_q, mem_read_d;
  logic        ire_q, ire_d;
  logic [2:0]  ir_funsel_q, ir_funsel_d;
  logic [15:0] iri_q, iri_d;
  logic        pce_q, pce_d;
  logic [2:0]  pc_funsel_q, pc_funsel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Next-state: a read that returns data on its last allowed cycle is still accepted.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RD_LO;
          wait_d  = 8'h00;
        end
      end
      S_RD_LO, S_RD_HI: begin
        if (MemValid) begin
          byte_d  = MemData;
          state_d = (state_q == S_RD_LO) ? S_LD_LO : S_LD_HI;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = S_ERR;
          end
        end
      end
      S_LD_LO: begin
        state_d = S_RD_HI;
        wait_d  = 8'h00;
      end
      S_LD_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    mem_read_d  = (state_d == S_RD_LO) || (state_d == S_RD_HI);
    ire_d       = (state_d == S_LD_LO) || (state_d == S_LD_HI);
    pce_d       = ire_d;
    ir_funsel_d = FS_NONE;
    if (state_d == S_LD_LO) begin
      ir_funsel_d = FS_LOAD_LO;
    end else if (state_d == S_LD_HI) begin
      ir_funsel_d = FS_LOAD_HI;
    end
    iri_d       = ire_d ? {8'h00, byte_d} : 16'h0000;
    pc_funsel_d = pce_d ? FS_INC : FS_NONE;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      byte_q      <= 8'h00;
      wait_q      <= 8'h00;
      mem_read_q  <= 1'b0;
      ire_q       <= 1'b0;
      ir_funsel_q <= FS_NONE;
      iri_q       <= 16'h0000;
      pce_q       <= 1'b0;
      pc_funsel_q <= FS_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      wait_q      <= wait_d;
      mem_read_q  <= mem_read_d;
      ire_q       <= ire_d;
      ir_funsel_q <= ir_funsel_d;
      iri_q       <= iri_d;
      pce_q       <= pce_d;
      pc_funsel_q <= pc_funsel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // The address follows PC live: the PC Register steps on the same edge that enters RD_HI.
  assign MemAddr  = mem_read_q ? PC : 16'h0000;
  assign MemRead  = mem_read_q;
  assign IRE      = ire_q;
  assign IRFunSel = ir_funsel_q;
  assign IRI      = iri_q;
  assign PCE      = pce_q;
  assign PCFunSel = pc_funsel_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Randomized scoreboard bench: a byte memory, IR and PC register models surround the
// sequencer; each fetch pushes its predicted outcome, a monitor checks Done/Error.
module tb_ir_fetch_sequencer;
  localparam int TIMEOUT = 15;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] PC;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemValid;
  logic [7:0]  MemData;
  logic        IRE;
  logic [2:0]  IRFunSel;
  logic [15:0] IRI;
  logic        PCE;
  logic [2:0]  PCFunSel;
  logic        Busy;
  logic        Done;
  logic        Error;

  ir_fetch_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PC(PC),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemValid(MemValid), .MemData(MemData),
    .IRE(IRE), .IRFunSel(IRFunSel), .IRI(IRI),
    .PCE(PCE), .PCFunSel(PCFunSel),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    bit          is_err;
    logic [15:0] ir;
    logic [15:0] pc;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] ir_reg = 16'h0000;
  logic [15:0] ir_exp = 16'h0000;
  logic [15:0] cur_base = 16'h0000;
  int          cur_dlo = 0;
  int          cur_dhi = 0;
  int          read_idx = 0;
  int          wait_left = 0;
  bit          in_read = 0;
  logic        s_ire, s_pce;
  logic [2:0]  s_irf, s_pcf;
  logic [15:0] s_iri;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder plus IR/PC register models, all updated after the clock edge.
  initial begin
    MemValid = 1'b0;
    MemData  = 8'h00;
    forever begin
      @(negedge Clock);
      s_ire = IRE; s_irf = IRFunSel; s_iri = IRI; s_pce = PCE; s_pcf = PCFunSel;
      if (!Reset && MemRead && read_idx >= 1)
        check("mem_addr", 32'(MemAddr), 32'(16'(cur_base + 16'(read_idx - 1))));
      @(posedge Clock);
      #1;
      if (!Reset) begin
        if (s_ire && s_irf == 3'b101) ir_reg[7:0] = s_iri[7:0];
        if (s_ire && s_irf == 3'b110) ir_reg[15:8] = s_iri[7:0];
        if (s_pce && s_pcf == 3'b001) PC = PC + 16'd1;
      end
      #1;
      if (Reset) begin
        MemValid = 1'b0;
        in_read  = 1'b0;
      end else if (MemRead) begin
        if (!in_read) begin
          in_read = 1'b1;
          check("read_index", 32'(read_idx < 2), 32'd1);
          wait_left = (read_idx == 0) ? cur_dlo : cur_dhi;
          read_idx++;
        end
        if (wait_left == 0) begin
          MemValid = 1'b1;
          MemData  = mem[MemAddr];
        end else begin
          wait_left--;
          MemValid = 1'b0;
          MemData  = 8'($urandom);
        end
      end else begin
        in_read  = 1'b0;
        MemValid = ($urandom_range(0, 3) == 0);
        MemData  = 8'($urandom);
      end
    end
  end

  // Monitor: every completion pulse consumes one prediction.
  always @(negedge Clock) begin
    if (!Reset && (Done || Error)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_completion: Done=%0b Error=%0b, expected no completion", Done, Error);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_error"}, 32'(Error), 32'(mon_e.is_err));
        check({mon_e.name, "_done"}, 32'(Done), 32'(!mon_e.is_err));
        check({mon_e.name, "_ir"}, 32'(ir_reg), 32'(mon_e.ir));
        check({mon_e.name, "_pc"}, 32'(PC), 32'(mon_e.pc));
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.lat));
        $display("txn %s: err=%0b ir=%h pc=%h cycles=%0d", mon_e.name, Error, ir_reg, PC,
                 cyc - mon_e.start_cyc + 1);
      end
    end
  end

  function automatic exp_t predict(input string name, input logic [15:0] pc0,
                                   input logic [7:0] lo, input logic [7:0] hi,
                                   input int dlo, input int dhi);
    exp_t e;
    e.name = name;
    e.start_cyc = 0;
    if (dlo >= TIMEOUT) begin
      e.is_err = 1'b1; e.ir = ir_exp; e.pc = pc0; e.lat = 1 + TIMEOUT;
    end else if (dhi >= TIMEOUT) begin
      e.is_err = 1'b1; e.ir = {ir_exp[15:8], lo}; e.pc = 16'(pc0 + 16'd1); e.lat = 3 + dlo + TIMEOUT;
    end else begin
      e.is_err = 1'b0; e.ir = {hi, lo}; e.pc = 16'(pc0 + 16'd2); e.lat = 5 + dlo + dhi;
    end
    ir_exp = e.ir;
    return e;
  endfunction

  task automatic wait_done(input bit pulses);
    int n = 0;
    do begin
      @(negedge Clock);
      Start = pulses && Busy && ($urandom_range(0, 2) == 0);
      n++;
    end while ((exp_q.size() != 0 || Busy) && n < 2000);
    Start = 1'b0;
    if (n >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL completion_timeout: still busy after %0d cycles, expected return to idle", n);
      exp_q.delete();
    end
  endtask

  task automatic setup(input logic [15:0] pc0, input logic [7:0] lo, input logic [7:0] hi,
                       input int dlo, input int dhi);
    PC = pc0;
    mem[pc0] = lo;
    mem[16'(pc0 + 16'd1)] = hi;
    cur_base = pc0; cur_dlo = dlo; cur_dhi = dhi; read_idx = 0;
  endtask

  task automatic fetch(input string name, input logic [15:0] pc0, input logic [7:0] lo,
                       input logic [7:0] hi, input int dlo, input int dhi, input bit pulses);
    exp_t e;
    @(negedge Clock);
    setup(pc0, lo, hi, dlo, dhi);
    Start = 1'b1;
    e = predict(name, pc0, lo, hi, dlo, dhi);
    @(posedge Clock);
    #1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    wait_done(pulses);
  endtask

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    if (r < 5) return $urandom_range(0, 3);
    if (r < 8) return $urandom_range(TIMEOUT - 2, TIMEOUT);
    return 255;
  endfunction

  initial begin
    exp_t e;
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    PC    = 16'h0000;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_ire", 32'(IRE), 32'd0);
    check("rst_irfunsel", 32'(IRFunSel), 32'd0);
    check("rst_iri", 32'(IRI), 32'd0);
    check("rst_pce", 32'(PCE), 32'd0);
    check("rst_pcfunsel", 32'(PCFunSel), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    Reset = 1'b0;

    fetch("basic", 16'h0040, 8'h34, 8'h12, 0, 0, 1'b0);
    fetch("wait3", 16'h0040, 8'h34, 8'h12, 3, 3, 1'b0);
    fetch("lo_timeout", 16'h0100, 8'h55, 8'h66, 255, 0, 1'b0);
    fetch("hi_timeout", 16'h0200, 8'h77, 8'h88, 1, 255, 1'b0);
    fetch("edge_accept", 16'h0300, 8'h9A, 8'hBC, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
    fetch("edge_timeout", 16'h0310, 8'h11, 8'h22, TIMEOUT, 0, 1'b0);

    // Reset while waiting in the high-byte read.
    @(negedge Clock);
    setup(16'h0400, 8'h5A, 8'hA5, 0, 255);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (read_idx < 2 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("reached_rd_hi", 32'(read_idx), 32'd2);
    repeat (3) @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_memread", 32'(MemRead), 32'd0);
    check("async_rst_ire", 32'(IRE), 32'd0);
    ir_exp = {ir_exp[15:8], 8'h5A};
    check("async_rst_ir", 32'(ir_reg), 32'(ir_exp));
    check("async_rst_pc", 32'(PC), 32'h0401);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    fetch("after_reset", 16'h0500, 8'hEF, 8'hBE, 0, 2, 1'b0);

    fetch("wrap", 16'hFFFF, 8'hCD, 8'hAB, 1, 2, 1'b1);
    repeat (4) @(negedge Clock);
    check("idle_after_pulses", 32'(Busy), 32'd0);

    // Start held high: a second fetch follows two cycles after Done.
    @(negedge Clock);
    setup(16'h0600, 8'h01, 8'h02, 0, 0);
    mem[16'h0602] = 8'h03;
    mem[16'h0603] = 8'h04;
    Start = 1'b1;
    e = predict("held1", 16'h0600, 8'h01, 8'h02, 0, 0);
    @(posedge Clock);
    #1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    n = 0;
    do begin @(negedge Clock); n++; end while (!Done && n < 200);
    cur_base = 16'h0602; cur_dlo = 0; cur_dhi = 0; read_idx = 0;
    e = predict("held2", 16'h0602, 8'h03, 8'h04, 0, 0);
    e.start_cyc = cyc + 2;
    exp_q.push_back(e);
    n = 0;
    do begin @(negedge Clock); n++; end while (!Done && n < 200);
    Start = 1'b0;
    wait_done(1'b0);

    for (int t = 0; t < 40; t++) begin
      fetch("rand", 16'($urandom), 8'($urandom), 8'($urandom), pick_delay(), pick_delay(),
            1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge Clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
